// File: rtl/adc_flash_reader.sv
// Conversion sequencer and result reader for the 3-bit flash ADC back end.
// Strobes the converter, captures and cross-checks codes, averages a burst and streams the result.
//
//  state   | meaning
//  IDLE    | waiting for start
//  SAMPLE  | samp held high for SAMP_CYCLES
//  CONVERT | waiting for eoc (first cycle masked) or timeout
//  CAPTURE | accumulate code, count errors
//  GAP     | idle spacing before next sample
//  LOAD    | first cycle of a presented result word
//  HOLD    | result held until handshake
module adc_flash_reader #(
    parameter int SAMP_CYCLES    = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int AVG_LOG2       = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                continuous_i,
    output logic                samp_o,
    input  logic                eoc_i,
    input  logic [9:0]          b_in_i,
    input  logic [9:0]          bn_in_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [2:0]          out_mean_o,
    output logic [2+AVG_LOG2:0] out_sum_o,
    output logic                out_err_o,
    output logic                busy_o,
    output logic [7:0]          err_cnt_o
);

    localparam int AW    = 3 + AVG_LOG2;
    localparam int CW    = AVG_LOG2 + 1;
    localparam int NCONV = 1 << AVG_LOG2;
    localparam int T1    = (SAMP_CYCLES > GAP_CYCLES) ? SAMP_CYCLES : GAP_CYCLES;
    localparam int TMAX  = (T1 > TIMEOUT_CYCLES) ? T1 : TIMEOUT_CYCLES;
    localparam int TW    = $clog2(TMAX + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SAMPLE  = 3'd1;
    localparam logic [2:0] S_CONVERT = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;
    localparam logic [2:0] S_LOAD    = 3'd5;
    localparam logic [2:0] S_HOLD    = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          flag_q, flag_d;
    logic          first_q, first_d;
    logic          to_q, to_d;
    logic          valid_q, valid_d;
    logic [AW-1:0] sum_q, sum_d;
    logic [2:0]    mean_q, mean_d;
    logic          err_q, err_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic [2:0]    code;
    logic          bad;
    logic          unused_bits;

    assign unused_bits = ^{b_in_i[9:3], bn_in_i[9:3]};
    assign code = to_q ? 3'd0 : b_in_i[2:0];
    assign bad  = to_q || (b_in_i[2:0] != bn_in_i[2:0]);

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        flag_d    = flag_q;
        first_d   = first_q;
        to_d      = to_q;
        valid_d   = valid_q;
        sum_d     = sum_q;
        mean_d    = mean_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_SAMPLE;
                    tmr_d   = TW'(SAMP_CYCLES - 1);
                    acc_d   = '0;
                    cnt_d   = '0;
                    flag_d  = 1'b0;
                end
            end
            S_SAMPLE: begin
                if (tmr_q == '0) begin
                    state_d = S_CONVERT;
                    tmr_d   = TW'(TIMEOUT_CYCLES - 1);
                    first_d = 1'b1;
                    to_d    = 1'b0;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_CONVERT: begin
                // eoc seen in the first CONVERT cycle may be left over from the previous conversion
                first_d = 1'b0;
                if (!first_q && eoc_i) begin
                    state_d = S_CAPTURE;
                end else if (tmr_q == '0) begin
                    state_d = S_CAPTURE;
                    to_d    = 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_CAPTURE: begin
                acc_d = acc_q + AW'(code);
                cnt_d = cnt_q + 1'b1;
                if (bad) begin
                    flag_d = 1'b1;
                    if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                end
                // Result registers load on entry to LOAD so out_valid is already up during LOAD
                if (cnt_q == CW'(NCONV - 1)) begin
                    state_d = S_LOAD;
                    sum_d   = acc_d;
                    mean_d  = 3'(acc_d >> AVG_LOG2);
                    err_d   = flag_d;
                    valid_d = 1'b1;
                end else if (GAP_CYCLES == 0) begin
                    state_d = S_SAMPLE;
                    tmr_d   = TW'(SAMP_CYCLES - 1);
                end else begin
                    state_d = S_GAP;
                    tmr_d   = TW'(GAP_CYCLES - 1);
                end
            end
            S_GAP: begin
                if (tmr_q == '0) begin
                    state_d = S_SAMPLE;
                    tmr_d   = TW'(SAMP_CYCLES - 1);
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_LOAD, S_HOLD: begin
                if (valid_q && out_ready_i) begin
                    valid_d = 1'b0;
                    if (continuous_i) begin
                        state_d = S_SAMPLE;
                        tmr_d   = TW'(SAMP_CYCLES - 1);
                        acc_d   = '0;
                        cnt_d   = '0;
                        flag_d  = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            tmr_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            flag_q    <= 1'b0;
            first_q   <= 1'b0;
            to_q      <= 1'b0;
            valid_q   <= 1'b0;
            sum_q     <= '0;
            mean_q    <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            flag_q    <= flag_d;
            first_q   <= first_d;
            to_q      <= to_d;
            valid_q   <= valid_d;
            sum_q     <= sum_d;
            mean_q    <= mean_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign samp_o      = (state_q == S_SAMPLE);
    assign busy_o      = (state_q != S_IDLE);
    assign out_valid_o = valid_q;
    assign out_sum_o   = sum_q;
    assign out_mean_o  = mean_q;
    assign out_err_o   = err_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_adc_flash_reader.sv
// Self-checking bench for adc_flash_reader: behavioural converter plus burst-level reference model.
// A second instance covers the single-conversion (AVG_LOG2=0) configuration.
module tb_adc_flash_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, cont, eoc, ready;
    logic [9:0] b_in, bn_in;
    logic       samp, valid, err, busy;
    logic [2:0] mean;
    logic [4:0] sum;
    logic [7:0] errcnt;

    logic       start2, cont2, eoc2, ready2;
    logic [9:0] b2, bn2;
    logic       samp2, valid2, err2, busy2;
    logic [2:0] mean2;
    logic [2:0] sum2;
    logic [7:0] errcnt2;

    always #5 clk = ~clk;

    adc_flash_reader dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .continuous_i(cont),
        .samp_o(samp), .eoc_i(eoc), .b_in_i(b_in), .bn_in_i(bn_in),
        .out_valid_o(valid), .out_ready_i(ready), .out_mean_o(mean),
        .out_sum_o(sum), .out_err_o(err), .busy_o(busy), .err_cnt_o(errcnt)
    );

    adc_flash_reader #(.AVG_LOG2(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .start_i(start2), .continuous_i(cont2),
        .samp_o(samp2), .eoc_i(eoc2), .b_in_i(b2), .bn_in_i(bn2),
        .out_valid_o(valid2), .out_ready_i(ready2), .out_mean_o(mean2),
        .out_sum_o(sum2), .out_err_o(err2), .busy_o(busy2), .err_cnt_o(errcnt2)
    );

    int n_checks = 0;
    int n_err    = 0;

    // converter model state and per-burst code tables
    logic [9:0] cb  [0:15];
    logic [9:0] cbn [0:15];
    int         cidx;
    bit         seen, stuck;
    logic [9:0] cb2, cbn2;
    bit         seen2;
    int         exp_errcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: advance to the falling edge, then update the converters.
    task automatic tick();
        @(negedge clk);
        if (samp === 1'b1) begin
            eoc  = 1'b0;
            seen = 1'b1;
        end else if (seen) begin
            seen = 1'b0;
            if (!stuck) begin
                eoc   = 1'b1;
                b_in  = cb[cidx];
                bn_in = cbn[cidx];
            end
            if (cidx < 15) cidx++;
        end
        if (samp2 === 1'b1) begin
            eoc2  = 1'b0;
            seen2 = 1'b1;
        end else if (seen2) begin
            seen2 = 1'b0;
            eoc2  = 1'b1;
            b2    = cb2;
            bn2   = cbn2;
        end
    endtask

    task automatic fill_random(input int mism_pct);
        for (int i = 0; i < 4; i++) begin
            logic [2:0] low;
            low    = 3'($urandom_range(0, 7));
            cb[i]  = {7'($urandom), low};
            if ($urandom_range(0, 99) < mism_pct)
                cbn[i] = {7'($urandom), low ^ 3'($urandom_range(1, 7))};
            else
                cbn[i] = {7'($urandom), low};
        end
        cidx = 0;
    endtask

    task automatic predict(output int esum, output bit eerr);
        esum = 0;
        eerr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            int code;
            bit bad;
            if (stuck) begin
                code = 0;
                bad  = 1'b1;
            end else begin
                code = int'(cb[i][2:0]);
                bad  = (cb[i][2:0] != cbn[i][2:0]);
            end
            esum += code;
            if (bad) begin
                eerr = 1'b1;
                if (exp_errcnt < 255) exp_errcnt++;
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(output int lat, input int limit);
        lat = 0;
        while (valid !== 1'b1 && lat < limit) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_word(input string tag, input int esum, input bit eerr);
        chk({tag, "_valid"}, valid, 1);
        chk({tag, "_sum"}, sum, esum);
        chk({tag, "_mean"}, mean, esum >> 2);
        chk({tag, "_err"}, err, eerr);
        chk({tag, "_errcnt"}, errcnt, exp_errcnt);
    endtask

    task automatic run_burst(input string tag, input int exp_lat);
        int esum, lat;
        bit eerr;
        predict(esum, eerr);
        pulse_start();
        wait_valid(lat, 300);
        chk({tag, "_latency"}, lat, exp_lat);
        check_word(tag, esum, eerr);
        tick();
        chk({tag, "_valid_drop"}, valid, 0);
        tick();
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int  esum, lat, bad_cnt;
        bit  eerr;
        logic [4:0] snap_sum;
        logic [2:0] snap_mean;
        logic       snap_err;

        rst_n = 1'b0; start = 1'b0; cont = 1'b0; ready = 1'b1; eoc = 1'b0;
        b_in = '0; bn_in = '0; start2 = 1'b0; cont2 = 1'b0; ready2 = 1'b1;
        eoc2 = 1'b0; b2 = '0; bn2 = '0; cidx = 0; seen = 0; seen2 = 0; stuck = 0;
        exp_errcnt = 0; cb2 = '0; cbn2 = '0;
        for (int i = 0; i < 16; i++) begin
            cb[i]  = '0;
            cbn[i] = '0;
        end
        tick(); tick();
        chk("rst_samp", samp, 0);
        chk("rst_valid", valid, 0);
        chk("rst_mean", mean, 0);
        chk("rst_sum", sum, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_errcnt", errcnt, 0);
        rst_n = 1'b1;
        tick();

        // Directed codes 3,3,4,5
        cb[0] = 10'd3; cb[1] = 10'd3; cb[2] = 10'd4; cb[3] = 10'd5;
        for (int i = 0; i < 4; i++) cbn[i] = cb[i];
        cidx = 0;
        run_burst("t1", 34);

        // One mismatching conversion, then a clean burst
        fill_random(0);
        cb[1]  = {7'($urandom), 3'd5};
        cbn[1] = {7'($urandom), 3'd1};
        run_burst("t2_mis", 34);
        fill_random(0);
        run_burst("t2_clean", 34);

        for (int k = 0; k < 4; k++) begin
            fill_random(30);
            run_burst("rand", 34);
        end

        // eoc stuck low: every conversion times out
        stuck = 1'b1;
        fill_random(0);
        run_burst("t3_timeout", 90);
        stuck = 1'b0;

        // continuous mode with a stalled consumer
        cont  = 1'b1;
        ready = 1'b0;
        fill_random(0);
        predict(esum, eerr);
        pulse_start();
        wait_valid(lat, 300);
        chk("t4_latency", lat, 34);
        check_word("t4_w0", esum, eerr);
        snap_sum = sum; snap_mean = mean; snap_err = err;
        fill_random(30);
        bad_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (valid !== 1'b1 || sum !== snap_sum || mean !== snap_mean ||
                err !== snap_err || samp !== 1'b0 || busy !== 1'b1)
                bad_cnt++;
        end
        chk("t4_hold_stable", bad_cnt, 0);
        predict(esum, eerr);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        cont  = 1'b0;
        chk("t4_valid_drop", valid, 0);
        chk("t4_restart_samp", samp, 1);
        wait_valid(lat, 300);
        chk("t4_latency2", lat, 34);
        check_word("t4_w1", esum, eerr);
        ready = 1'b1;
        tick();
        chk("t4_valid_drop2", valid, 0);
        chk("t4_idle", busy, 0);

        // asynchronous reset in the middle of SAMPLE
        fill_random(0);
        pulse_start();
        tick(); tick();
        chk("t5_in_sample", samp, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_samp", samp, 0);
        chk("t5_valid", valid, 0);
        chk("t5_errcnt", errcnt, 0);
        chk("t5_busy", busy, 0);
        exp_errcnt = 0;
        tick();
        eoc = 1'b0; seen = 1'b0; eoc2 = 1'b0; seen2 = 1'b0;
        rst_n = 1'b1;
        tick();
        fill_random(0);
        run_burst("t5_after", 34);

        // single-conversion instance, upper code bits set
        cb2  = 10'h3FF;
        cbn2 = 10'h007;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        lat = 0;
        while (valid2 !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        chk("t6_latency", lat, 7);
        chk("t6_sum", sum2, 7);
        chk("t6_mean", mean2, 7);
        chk("t6_err", err2, 0);
        chk("t6_errcnt", errcnt2, 0);
        tick();
        chk("t6_valid_drop", valid2, 0);

        cb2  = {7'($urandom), 3'($urandom_range(0, 7))};
        cbn2 = {7'($urandom), cb2[2:0] ^ 3'd2};
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        lat = 0;
        while (valid2 !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        chk("t6b_latency", lat, 7);
        chk("t6b_sum", sum2, cb2[2:0]);
        chk("t6b_mean", mean2, cb2[2:0]);
        chk("t6b_err", err2, 1);
        chk("t6b_errcnt", errcnt2, 1);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
